// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel shifter bank: default pixel geometry,
// the pixels-per-word helper and the per-channel FSM state type.
package pixel_pkg;

  localparam int BPP_DEFAULT    = 2;
  localparam int WORD_W_DEFAULT = 32;

  // Number of BPP-bit pixels packed into one pattern word.
  function automatic int pix_per_word(input int word_w, input int bpp);
    return word_w / bpp;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2
  } chan_state_t;

endpackage

// File: rtl/pixel_shift_channel.sv
// One pixel shift channel: holds a pattern word, waits a programmable
// number of pixel ticks, then serialises BPP-bit pixels (optionally mirrored).
module pixel_shift_channel
  import pixel_pkg::*;
#(
  parameter int BPP    = BPP_DEFAULT,
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int XCNT_W = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_en,
  input  logic              line_start,
  input  logic              load,
  input  logic [WORD_W-1:0] load_data,
  input  logic [XCNT_W-1:0] load_xpos,
  input  logic              load_flip,
  output logic [BPP-1:0]    ch_pix,
  output logic              ch_active
);

  localparam int PIX_PER_WORD = pix_per_word(WORD_W, BPP);
  localparam int REM_W        = $clog2(PIX_PER_WORD + 1);
  localparam logic [REM_W-1:0] REM_FULL = REM_W'(PIX_PER_WORD);

  chan_state_t       state;
  logic [WORD_W-1:0] pat_buf;
  logic [REM_W-1:0]  remaining;
  logic [XCNT_W-1:0] xcnt;

  // Reverse pixel order within the word; bits inside each pixel keep their order.
  function automatic logic [WORD_W-1:0] flip_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      r[(PIX_PER_WORD-1-i)*BPP +: BPP] = w[i*BPP +: BPP];
    end
    return r;
  endfunction

  // Channel FSM: load beats line_start, line_start beats the pixel tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pat_buf   <= '0;
      remaining <= '0;
      xcnt      <= '0;
      ch_pix    <= '0;
      ch_active <= 1'b0;
    end else if (load) begin
      pat_buf   <= load_flip ? flip_word(load_data) : load_data;
      remaining <= REM_FULL;
      xcnt      <= load_xpos;
      state     <= (load_xpos == '0) ? SHIFT : WAIT;
      ch_pix    <= '0;
      ch_active <= 1'b0;
    end else if (line_start) begin
      state     <= IDLE;
      ch_pix    <= '0;
      ch_active <= 1'b0;
    end else if (pix_en) begin
      case (state)
        WAIT: begin
          ch_pix    <= '0;
          ch_active <= 1'b0;
          // The tick that sees xcnt==1 is the last wait tick; the next one shifts.
          if (xcnt != '0) xcnt <= xcnt - XCNT_W'(1);
          if (xcnt <= XCNT_W'(1)) state <= SHIFT;
        end
        SHIFT: begin
          ch_pix    <= pat_buf[BPP-1:0];
          pat_buf   <= pat_buf >> BPP;
          ch_active <= 1'b1;
          remaining <= remaining - REM_W'(1);
          if (remaining <= REM_W'(1)) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          ch_pix    <= '0;
          ch_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pixel_shifter_bank.sv
// Bank of NUM_CH pixel shift channels followed by a registered priority
// mux that picks the lowest-index opaque active channel.
// Optional sticky sprite-0 collision flag: define PIXEL_SHIFTER_COLLISION_EN.
module pixel_shifter_bank
  import pixel_pkg::*;
#(
  parameter int NUM_CH = 9,
  parameter int BPP    = BPP_DEFAULT,
  parameter int WORD_W = WORD_W_DEFAULT,
  parameter int XCNT_W = 9,
  localparam int SRC_W = $clog2(NUM_CH + 1)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           pix_en,
  input  logic                           line_start,
  input  logic [NUM_CH-1:0]              load,
  input  logic [NUM_CH-1:0][WORD_W-1:0]  load_data,
  input  logic [NUM_CH-1:0][XCNT_W-1:0]  load_xpos,
  input  logic [NUM_CH-1:0]              load_flip,
  output logic [NUM_CH-1:0][BPP-1:0]     ch_pix,
  output logic [NUM_CH-1:0]              ch_active,
  output logic [BPP-1:0]                 pix_out,
  output logic [SRC_W-1:0]               pix_src,
  output logic                           pix_valid
`ifdef PIXEL_SHIFTER_COLLISION_EN
  ,
  input  logic                           collision_clr,
  output logic                           collision
`endif
);

  logic [NUM_CH-1:0] ch_opq;
  logic [BPP-1:0]    win_pix;
  logic [SRC_W-1:0]  win_src;
  logic              win_hit;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pixel_shift_channel #(
      .BPP    (BPP),
      .WORD_W (WORD_W),
      .XCNT_W (XCNT_W)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .pix_en     (pix_en),
      .line_start (line_start),
      .load       (load[g]),
      .load_data  (load_data[g]),
      .load_xpos  (load_xpos[g]),
      .load_flip  (load_flip[g]),
      .ch_pix     (ch_pix[g]),
      .ch_active  (ch_active[g])
    );
  end

  // A channel is a candidate when it emitted a pixel that is not transparent.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_opq[i] = ch_active[i] && (ch_pix[i] != '0);
    end
  end

  // Lowest-index opaque channel wins; scan from the top so the lowest overrides.
  always_comb begin
    win_pix = '0;
    win_src = SRC_W'(NUM_CH);
    win_hit = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_opq[i]) begin
        win_pix = ch_pix[i];
        win_src = SRC_W'(i);
        win_hit = 1'b1;
      end
    end
  end

  // ---- stage p1: priority output register, updated every clk ----
  // Priority output register: follows ch_pix one clk later, independent of pix_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_out   <= '0;
      pix_src   <= SRC_W'(NUM_CH);
      pix_valid <= 1'b0;
    end else begin
      pix_out   <= win_pix;
      pix_src   <= win_src;
      pix_valid <= win_hit;
    end
  end

`ifdef PIXEL_SHIFTER_COLLISION_EN
  logic vld_p1;
  logic coll_set;

  // Remember that the channel outputs were just refreshed by a pixel tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= pix_en;
  end

  assign coll_set = vld_p1 && ch_opq[0] && (|ch_opq[NUM_CH-1:1]);

  // Sticky collision flag; a simultaneous set overrides the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          collision <= 1'b0;
    else if (coll_set)     collision <= 1'b1;
    else if (collision_clr) collision <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pixel_shifter_bank.sv
// Directed + randomized bench for pixel_shifter_bank with a tick-count
// reference model of every channel.
module tb_pixel_shifter_bank;

  localparam int NUM_CH = 9;
  localparam int BPP    = 2;
  localparam int WORD_W = 32;
  localparam int XCNT_W = 9;
  localparam int SRC_W  = $clog2(NUM_CH + 1);
  localparam int PPW    = WORD_W / BPP;

  logic                          clk;
  logic                          reset_n;
  logic                          pix_en;
  logic                          line_start;
  logic [NUM_CH-1:0]             load;
  logic [NUM_CH-1:0][WORD_W-1:0] load_data;
  logic [NUM_CH-1:0][XCNT_W-1:0] load_xpos;
  logic [NUM_CH-1:0]             load_flip;
  logic [NUM_CH-1:0][BPP-1:0]    ch_pix;
  logic [NUM_CH-1:0]             ch_active;
  logic [BPP-1:0]                pix_out;
  logic [SRC_W-1:0]              pix_src;
  logic                          pix_valid;
`ifdef PIXEL_SHIFTER_COLLISION_EN
  logic                          collision_clr;
  logic                          collision;
  logic                          m_coll;
  logic                          m_pe_prev;
`endif

  int tests;
  int fails;

  // Reference model: a channel is a word plus a count of ticks since load.
  logic [WORD_W-1:0] m_word  [NUM_CH];
  logic              m_flip  [NUM_CH];
  int                m_xpos  [NUM_CH];
  int                m_ticks [NUM_CH];
  logic              m_live  [NUM_CH];
  logic [BPP-1:0]    m_pix   [NUM_CH];
  logic              m_act   [NUM_CH];

  pixel_shifter_bank #(
    .NUM_CH (NUM_CH),
    .BPP    (BPP),
    .WORD_W (WORD_W),
    .XCNT_W (XCNT_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pix_en     (pix_en),
    .line_start (line_start),
    .load       (load),
    .load_data  (load_data),
    .load_xpos  (load_xpos),
    .load_flip  (load_flip),
    .ch_pix     (ch_pix),
    .ch_active  (ch_active),
    .pix_out    (pix_out),
    .pix_src    (pix_src),
    .pix_valid  (pix_valid)
`ifdef PIXEL_SHIFTER_COLLISION_EN
    ,
    .collision_clr (collision_clr),
    .collision     (collision)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_word[c] = '0; m_flip[c] = 1'b0; m_xpos[c] = 0; m_ticks[c] = 0;
      m_live[c] = 1'b0; m_pix[c] = '0; m_act[c] = 1'b0;
    end
`ifdef PIXEL_SHIFTER_COLLISION_EN
    m_coll = 1'b0;
    m_pe_prev = 1'b0;
`endif
  endtask

  // One clk with the given controls; compares every output against the model.
  task automatic step(input logic pe, input logic ls, input logic [NUM_CH-1:0] ld);
    logic [BPP-1:0]             e_out;
    logic [SRC_W-1:0]           e_src;
    logic                       e_val;
    logic [NUM_CH-1:0][BPP-1:0] e_pix;
    logic [NUM_CH-1:0]          e_act;
    int k;
    int idx;
    pix_en = pe; line_start = ls; load = ld;
    e_out = '0; e_src = SRC_W'(NUM_CH); e_val = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (!e_val && m_act[c] && m_pix[c] != '0) begin
        e_out = m_pix[c]; e_src = SRC_W'(c); e_val = 1'b1;
      end
    end
`ifdef PIXEL_SHIFTER_COLLISION_EN
    begin
      logic other;
      other = 1'b0;
      for (int c = 1; c < NUM_CH; c++) if (m_act[c] && m_pix[c] != '0) other = 1'b1;
      if (m_pe_prev && m_act[0] && m_pix[0] != '0 && other) m_coll = 1'b1;
      else if (collision_clr) m_coll = 1'b0;
      m_pe_prev = pe;
    end
`endif
    @(posedge clk);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ld[c]) begin
        m_word[c] = load_data[c]; m_flip[c] = load_flip[c];
        m_xpos[c] = int'(load_xpos[c]); m_ticks[c] = 0; m_live[c] = 1'b1;
        m_pix[c] = '0; m_act[c] = 1'b0;
      end else if (ls) begin
        m_live[c] = 1'b0; m_pix[c] = '0; m_act[c] = 1'b0;
      end else if (pe) begin
        m_pix[c] = '0; m_act[c] = 1'b0;
        if (m_live[c]) begin
          if (m_ticks[c] >= m_xpos[c]) begin
            k = m_ticks[c] - m_xpos[c];
            idx = m_flip[c] ? (PPW - 1 - k) : k;
            m_pix[c] = m_word[c][idx*BPP +: BPP];
            m_act[c] = 1'b1;
            if (k == PPW - 1) m_live[c] = 1'b0;
          end
          m_ticks[c]++;
        end
      end
    end
    #1;
    pix_en = 1'b0; line_start = 1'b0; load = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e_pix[c] = m_pix[c]; e_act[c] = m_act[c];
    end
    chk("ch_pix", 64'(ch_pix), 64'(e_pix));
    chk("ch_active", 64'(ch_active), 64'(e_act));
    chk("pix_out", 64'(pix_out), 64'(e_out));
    chk("pix_src", 64'(pix_src), 64'(e_src));
    chk("pix_valid", 64'(pix_valid), 64'(e_val));
`ifdef PIXEL_SHIFTER_COLLISION_EN
    chk("collision", 64'(collision), 64'(m_coll));
`endif
  endtask

  task automatic set_ch(input int c, input logic [WORD_W-1:0] d, input int xp, input logic fl);
    load_data[c] = d;
    load_xpos[c] = XCNT_W'(xp);
    load_flip[c] = fl;
  endtask

  initial begin
    logic [NUM_CH-1:0] ld;
    tests = 0; fails = 0;
    reset_n = 1'b0; pix_en = 1'b0; line_start = 1'b0; load = '0;
    load_data = '0; load_xpos = '0; load_flip = '0;
`ifdef PIXEL_SHIFTER_COLLISION_EN
    collision_clr = 1'b0;
`endif
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ch_pix", 64'(ch_pix), 64'd0);
    chk("rst_ch_active", 64'(ch_active), 64'd0);
    chk("rst_pix_out", 64'(pix_out), 64'd0);
    chk("rst_pix_src", 64'(pix_src), 64'(NUM_CH));
    chk("rst_pix_valid", 64'(pix_valid), 64'd0);
    reset_n = 1'b1;

    // Test 1: plain word, xpos 0, pix_en every clk.
    set_ch(0, 32'h0000_001B, 0, 1'b0);
    step(1'b0, 1'b0, 9'h001);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, '0);
      chk("t1_pix", 64'(ch_pix[0]), (i < 4) ? 64'(3 - i) : 64'd0);
      chk("t1_act", 64'(ch_active[0]), (i < 16) ? 64'd1 : 64'd0);
    end

    // Test 2: same word mirrored.
    set_ch(0, 32'h0000_001B, 0, 1'b1);
    step(1'b0, 1'b0, 9'h001);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, '0);
      chk("t2_pix", 64'(ch_pix[0]), (i >= 12 && i < 16) ? 64'(i - 12) : 64'd0);
      chk("t2_act", 64'(ch_active[0]), (i < 16) ? 64'd1 : 64'd0);
    end

    // Test 3: start delay of 5 with pix_en every other clk.
    set_ch(0, 32'h0000_001B, 5, 1'b0);
    step(1'b0, 1'b0, 9'h001);
    for (int t = 1; t <= 6; t++) begin
      step(1'b1, 1'b0, '0);
      chk("t3_act", 64'(ch_active[0]), (t == 6) ? 64'd1 : 64'd0);
      step(1'b0, 1'b0, '0);
      chk("t3_hold", 64'(ch_pix[0]), (t == 6) ? 64'd3 : 64'd0);
    end

    // Test 4: priority between ch0, ch3 and ch8.
    step(1'b0, 1'b1, '0);
    set_ch(0, 32'h0000_0004, 0, 1'b0);
    set_ch(3, 32'h0000_0002, 0, 1'b0);
    set_ch(8, 32'h0000_0001, 0, 1'b0);
    step(1'b0, 1'b0, 9'h109);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("t4_out_a", 64'(pix_out), 64'd2);
    chk("t4_src_a", 64'(pix_src), 64'd3);
    chk("t4_val_a", 64'(pix_valid), 64'd1);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("t4_src_b", 64'(pix_src), 64'd0);
    chk("t4_out_b", 64'(pix_out), 64'd1);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("t4_src_c", 64'(pix_src), 64'(NUM_CH));
    chk("t4_val_c", 64'(pix_valid), 64'd0);

    // Test 5: line_start together with a reload of ch2, mid-shift.
    step(1'b0, 1'b1, '0);
    set_ch(1, 32'hFFFF_FFFF, 0, 1'b0);
    set_ch(2, 32'hFFFF_FFFF, 0, 1'b0);
    step(1'b0, 1'b0, 9'h006);
    repeat (3) step(1'b1, 1'b0, '0);
    set_ch(2, 32'hFFFF_FFFE, 0, 1'b0);
    step(1'b1, 1'b1, 9'h004);
    chk("t5_ch1_act", 64'(ch_active[1]), 64'd0);
    chk("t5_ch1_pix", 64'(ch_pix[1]), 64'd0);
    step(1'b1, 1'b0, '0);
    chk("t5_ch1_idle", 64'(ch_active[1]), 64'd0);
    chk("t5_ch2_pix", 64'(ch_pix[2]), 64'd2);
    chk("t5_ch2_act", 64'(ch_active[2]), 64'd1);

    // Test 6: asynchronous reset mid-shift.
    step(1'b1, 1'b0, '0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_ch_pix", 64'(ch_pix), 64'd0);
    chk("t6_ch_active", 64'(ch_active), 64'd0);
    chk("t6_pix_out", 64'(pix_out), 64'd0);
    chk("t6_pix_src", 64'(pix_src), 64'(NUM_CH));
    chk("t6_pix_valid", 64'(pix_valid), 64'd0);
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1'b1, 1'b0, '0);
    chk("t6_after_act", 64'(ch_active), 64'd0);

`ifdef PIXEL_SHIFTER_COLLISION_EN
    // Collision between ch0 and ch4.
    set_ch(0, 32'h0000_0001, 0, 1'b0);
    set_ch(4, 32'h0000_0003, 0, 1'b0);
    step(1'b0, 1'b0, 9'h011);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("col_set", 64'(collision), 64'd1);
    step(1'b0, 1'b0, '0);
    chk("col_hold", 64'(collision), 64'd1);
    collision_clr = 1'b1;
    step(1'b0, 1'b0, '0);
    collision_clr = 1'b0;
    chk("col_clr", 64'(collision), 64'd0);
`endif

    // Randomized traffic checked against the model on every clk.
    for (int n = 0; n < 600; n++) begin
      ld = '0;
      if ($urandom_range(0, 4) == 0) begin
        ld = NUM_CH'($urandom) & NUM_CH'($urandom);
        for (int c = 0; c < NUM_CH; c++) begin
          if (ld[c]) set_ch(c, $urandom, $urandom_range(0, 12), 1'($urandom_range(0, 1)));
        end
      end
`ifdef PIXEL_SHIFTER_COLLISION_EN
      collision_clr = ($urandom_range(0, 7) == 0);
`endif
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 50) == 0), ld);
    end
`ifdef PIXEL_SHIFTER_COLLISION_EN
    collision_clr = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
